// File: rtl/vx_csr_timeit.sv
// Per-warp PC-range cycle timer exposed as a small CSR bank.
// Each (warp, range) cell runs between a START-PC commit and an END-PC commit, counting cycles and intervals.
module vx_csr_timeit #(
    parameter int          NUM_WARPS  = 4,
    parameter int          NUM_RANGES = 2,
    parameter int          CTR_WIDTH  = 48,
    parameter logic [11:0] CSR_BASE   = 12'hB20,
    localparam int         NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write_enable,
    input  logic [11:0]                    write_addr,
    input  logic [31:0]                    write_data,
    input  logic [11:0]                    read_addr,
    input  logic [NW_BITS-1:0]             read_wid,
    output logic [31:0]                    read_data,
    output logic                           read_hit,
    input  logic                           commit_valid,
    input  logic [NW_BITS-1:0]             commit_wid,
    input  logic [31:0]                    commit_pc,
    output logic [NUM_WARPS*NUM_RANGES-1:0] active_mask
);

    localparam int N         = NUM_RANGES;
    localparam int NUM_CELLS = NUM_WARPS * NUM_RANGES;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    logic [31:0]          start_q [N];
    logic [31:0]          start_d [N];
    logic [31:0]          end_q   [N];
    logic [31:0]          end_d   [N];
    logic [N-1:0]         armed_q;
    logic [N-1:0]         armed_d;
    logic [N-1:0]         wr_start;
    logic [N-1:0]         wr_end;
    logic [11:0]          wr_off;
    logic [11:0]          rd_off;
    logic                 wr_in;
    logic                 rd_in;

    logic [CTR_WIDTH-1:0] cnt_all  [NUM_CELLS];
    logic [15:0]          hits_all [NUM_CELLS];
    logic [NUM_CELLS-1:0] running;

    assign wr_off = write_addr - CSR_BASE;
    assign rd_off = read_addr - CSR_BASE;
    assign wr_in  = write_enable && (write_addr >= CSR_BASE);
    assign rd_in  = read_addr >= CSR_BASE;

    always_comb begin
        wr_start = '0;
        wr_end   = '0;
        for (int r = 0; r < N; r++) begin
            if (wr_in && wr_off == 12'(2 * r))     wr_start[r] = 1'b1;
            if (wr_in && wr_off == 12'(2 * r + 1)) wr_end[r]   = 1'b1;
        end
    end

    always_comb begin
        armed_d = armed_q;
        for (int r = 0; r < N; r++) begin
            start_d[r] = start_q[r];
            end_d[r]   = end_q[r];
            if (wr_start[r]) begin
                start_d[r] = write_data;
                armed_d[r] = 1'b0;
            end
            if (wr_end[r]) begin
                end_d[r]   = write_data;
                armed_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= '0;
            for (int r = 0; r < N; r++) begin
                start_q[r] <= '0;
                end_q[r]   <= '0;
            end
        end else begin
            armed_q <= armed_d;
            for (int r = 0; r < N; r++) begin
                start_q[r] <= start_d[r];
                end_q[r]   <= end_d[r];
            end
        end
    end

    // Cell gi serves warp gi % NUM_WARPS of range gi / NUM_WARPS, matching the active_mask bit order.
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        localparam int R = gi / NUM_WARPS;
        localparam int W = gi % NUM_WARPS;

        state_t               state_q;
        state_t               state_d;
        logic [CTR_WIDTH-1:0] cnt_q;
        logic [CTR_WIDTH-1:0] cnt_d;
        logic [15:0]          hits_q;
        logic [15:0]          hits_d;
        logic                 my_commit;

        assign my_commit = armed_q[R] && commit_valid && (commit_wid == NW_BITS'(W));

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hits_d  = hits_q;
            if (state_q == RUNNING && cnt_q != {CTR_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CTR_WIDTH'(1);
            end
            // A CSR write on this range wins over any commit in the same cycle.
            if (wr_end[R]) begin
                state_d = IDLE;
                cnt_d   = '0;
                hits_d  = '0;
            end else if (wr_start[R]) begin
                state_d = IDLE;
                cnt_d   = cnt_q;
            end else if (my_commit) begin
                if (state_q == IDLE && commit_pc == start_q[R]) begin
                    state_d = RUNNING;
                end else if (state_q == RUNNING && commit_pc == end_q[R]) begin
                    state_d = IDLE;
                    if (hits_q != 16'hFFFF) begin
                        hits_d = hits_q + 16'd1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                hits_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hits_q  <= hits_d;
            end
        end

        assign cnt_all[gi]  = cnt_q;
        assign hits_all[gi] = hits_q;
        assign running[gi]  = (state_q == RUNNING);
    end

    assign active_mask = running;

    logic [CTR_WIDTH-1:0] cnt_sel;
    logic [15:0]          hits_sel;
    logic                 wid_ok;
    int                   idx;

    always_comb begin
        read_hit  = 1'b0;
        read_data = '0;
        cnt_sel   = '0;
        hits_sel  = '0;
        idx       = 0;
        wid_ok    = int'(read_wid) < NUM_WARPS;
        if (rd_in) begin
            for (int r = 0; r < N; r++) begin
                idx      = r * NUM_WARPS + (wid_ok ? int'(read_wid) : 0);
                cnt_sel  = wid_ok ? cnt_all[idx] : '0;
                hits_sel = wid_ok ? hits_all[idx] : '0;
                if (rd_off == 12'(2 * r)) begin
                    read_hit  = 1'b1;
                    read_data = start_q[r];
                end
                if (rd_off == 12'(2 * r + 1)) begin
                    read_hit  = 1'b1;
                    read_data = end_q[r];
                end
                if (rd_off == 12'(2 * N + 2 * r)) begin
                    read_hit  = 1'b1;
                    read_data = cnt_sel[31:0];
                end
                if (rd_off == 12'(2 * N + 2 * r + 1)) begin
                    read_hit  = 1'b1;
                    read_data = 32'(cnt_sel >> 32);
                end
                if (rd_off == 12'(4 * N + r)) begin
                    read_hit  = 1'b1;
                    read_data = {16'd0, hits_sel};
                end
            end
            if (rd_off == 12'(5 * N)) begin
                read_hit  = 1'b1;
                read_data = 32'(armed_q);
            end
        end
    end

endmodule
